prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream of the cpu: loads a program into the shared 8-bit RAM from a byte stream while the cpu is held in its wait stage, then pulses the cpu `run` input.
- While busy, its RAM-side outputs drive the RAM address/data/wren through the top-level mux.
- When idle, the cpu owns the RAM.

Parameters:
- ADDR_W, 8, RAM address width; length and address counters are this width.
- BASE_ADDR, 8'h00, first RAM address written.
- AUTORUN, 1, 1 = pulse cpu_run after a successful load; 0 = never pulse.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle; transfer = in_valid & in_ready.
- abort  in  1  cancel current load.
- mem_addr  out  ADDR_W  RAM write address.
- mem_data  out  8  RAM write data.
- mem_wren  out  1  RAM write enable, one cycle per byte.
- busy  out  1  loader owns RAM; top-level RAM mux select.
- cpu_halt  out  1  held high while busy; forces the cpu to stop.
- cpu_run  out  1  single-cycle start pulse to the cpu.
- done  out  1  sticky: last load completed OK.
- err  out  1  sticky: last load aborted or failed checksum.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0; mem_addr=BASE_ADDR; mem_data=0; mem_wren=0; busy=0; cpu_halt=0; cpu_run=0; done=0; err=0; counters=0.
- All outputs are registered.
- States: IDLE, LEN, DATA, FLUSH, START (and CHK when the optional feature is enabled).
- IDLE:
  - in_ready=1, busy=0.
  - A transfer captures the length byte: remain = in_data, with 0 meaning 256.
  - The same transfer clears done/err and moves to LEN.
- LEN:
  - One cycle; busy=1, cpu_halt=1, in_ready=0.
  - Loads addr_cnt=BASE_ADDR, then moves to DATA.
- DATA:
  - in_ready=1, busy=1.
  - Each transfer registers mem_data=in_data, mem_addr=addr_cnt, and mem_wren=1 on the next cycle (write latency 1 cycle after acceptance).
  - On each transfer: addr_cnt += 1 mod 2^ADDR_W (wraps 8'hFF -> 8'h00); remain -= 1.
  - Throughput is 1 byte/cycle; cycles with in_valid=0 produce mem_wren=0.
  - The transfer that makes remain reach 0 moves to FLUSH (CHK if the optional feature is enabled).
- FLUSH:
  - in_ready=0; the final write completes this cycle.
  - Next state is START; done=1.
- START:
  - cpu_run=1 for exactly one cycle if AUTORUN=1, else 0.
  - busy and cpu_halt drop to 0 in this same cycle, so cpu_run is seen with halt low.
  - Returns to IDLE.
- abort:
  - In LEN, DATA or CHK: go to IDLE next cycle; err=1; mem_wren=0.
  - A byte accepted in the abort cycle is discarded.
  - No cpu_run; written bytes stay in RAM.
  - abort in IDLE, FLUSH or START is ignored.
- Simultaneous transfer and abort: abort wins.
- mem_wren is never asserted while busy=0.
- cpu_halt equals busy at all times.

Optional Feature:
- PROG_LOADER_CHECKSUM_EN defined:
  - The loader keeps an 8-bit running sum mod 256 of the data bytes.
  - After the last data byte it enters CHK (in_ready=1) and accepts one more byte.
  - Match: FLUSH -> START as normal.
  - Mismatch: err=1, done=0, no cpu_run, return to IDLE.
- PROG_LOADER_CHECKSUM_EN undefined: there is no CHK state and no trailing byte is consumed.

Decomposition:
- Shared package cpu_pkg: ADDR_W/data-width constants and the loader state enum (S_IDLE, S_LEN, S_DATA, S_CHK, S_FLUSH, S_START).
- Sub-module byte_counter (loadable 9-bit down-counter with zero flag) is used for remain.
- The address counter stays inline.

Test Plan:
- Stream 03, AA, BB, CC with in_valid held high:
  - mem_wren pulses at addresses 00, 01, 02 with data AA, BB, CC on consecutive cycles.
  - done=1 and cpu_run pulses once, 1 cycle after FLUSH, with cpu_halt already 0.
- BASE_ADDR=8'hFE, stream 03, 11, 22, 33: writes go to FE, FF, 00 (wrap); done=1.
- Stream 02, 55, then in_valid low for 5 cycles, then 66: no mem_wren during the gap; second write goes to addr 01.
- Stream 04, 01, 02, then abort: no further writes, err=1, done=0, no cpu_run, busy=0 next cycle.
- Length byte 00 followed by 256 bytes: 256 writes covering 00..FF, then a single cpu_run.
- With PROG_LOADER_CHECKSUM_EN:
  - Stream 02, 10, 20, 30: run pulses.
  - Stream 02, 10, 20, 31: err=1, no run.
- Assert rst mid-DATA: every output returns to its reset value immediately (async), with no extra mem_wren.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared cpu/loader constants and the program loader state encoding.
// Loader checksum option: PROG_LOADER_CHECKSUM_EN.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_FLUSH,
        S_START
    } ld_state_e;

endpackage

// File: rtl/byte_counter.sv
// Loadable down-counter with zero flag; tracks bytes left in a load.
module byte_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into RAM while holding the cpu, then starts it.
// Optional trailing checksum byte: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int                     ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]      BASE_ADDR = '0,
    parameter int                     AUTORUN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              cpu_halt,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    import cpu_pkg::*;

    ld_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_data_q, mem_data_d;
    logic               mem_wren_q, mem_wren_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               cpu_run_q, cpu_run_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic               xfer;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_ld_val;
    logic [CNT_W-1:0]   remain;
    logic               remain_zero;

    assign xfer       = in_valid & in_ready_q;
    // A length byte of zero encodes a full 256-byte image.
    assign cnt_ld_val = (in_data == 8'd0) ? CNT_W'(256) : CNT_W'(in_data);

    byte_counter #(
        .W (CNT_W)
    ) u_remain (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .count    (remain),
        .zero     (remain_zero)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    cnt_load = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_LEN;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d    = 8'd0;
`endif
                end
            end
            S_LEN: begin
                addr_d  = BASE_ADDR;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    mem_addr_d = addr_q;
                    mem_data_d = in_data;
                    mem_wren_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    cnt_dec    = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + in_data;
                    if (remain == CNT_W'(1)) state_d = S_CHK;
`else
                    if (remain == CNT_W'(1)) state_d = S_FLUSH;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
`endif
            S_FLUSH: begin
                state_d = S_START;
                done_d  = remain_zero;
            end
            S_START: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any same-cycle transfer; bytes already written stay.
        if (abort && (state_q == S_LEN || state_q == S_DATA ||
                      state_q == S_CHK)) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            done_d     = 1'b0;
            mem_wren_d = 1'b0;
            mem_addr_d = mem_addr_q;
            mem_data_d = mem_data_q;
            cnt_dec    = 1'b0;
        end

        in_ready_d = (state_d == S_IDLE) || (state_d == S_DATA) ||
                     (state_d == S_CHK);
        busy_d     = (state_d == S_LEN) || (state_d == S_DATA) ||
                     (state_d == S_CHK) || (state_d == S_FLUSH);
        cpu_run_d  = (state_d == S_START) && (AUTORUN != 0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= 8'd0;
            mem_wren_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cpu_run_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            cpu_run_q  <= cpu_run_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign busy     = busy_q;
    assign cpu_halt = busy_q;
    assign cpu_run  = cpu_run_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: base 00 and base FE instances share one stream.
// Checksum steps are included when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;

    logic       rdy0, wren0, busy0, halt0, run0, done0, err0;
    logic [7:0] addr0, data0;
    logic       rdy1, wren1, busy1, halt1, run1, done1, err1;
    logic [7:0] addr1, data1;

    int checks = 0;
    int errors = 0;
    int runs;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'h00), .AUTORUN(1)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .abort(abort), .mem_addr(addr0),
        .mem_data(data0), .mem_wren(wren0), .busy(busy0),
        .cpu_halt(halt0), .cpu_run(run0), .done(done0), .err(err0)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE), .AUTORUN(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .abort(abort), .mem_addr(addr1),
        .mem_data(data1), .mem_wren(wren1), .busy(busy1),
        .cpu_halt(halt1), .cpu_run(run1), .done(done1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] len);
        in_valid = 1'b1;
        in_data  = len;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
    endtask

    // Consumes the checksum byte when enabled, then steps into START.
    task automatic tail(input logic [7:0] sum);
`ifdef PROG_LOADER_CHECKSUM_EN
        put(sum);
        chk("chk_no_wren", {31'd0, wren0}, 32'd0);
`else
        chk("tail_sum_unused", {24'd0, sum}, {24'd0, sum});
        checks--;
`endif
        chk("flush_rdy", {31'd0, rdy0}, 32'd0);
        chk("flush_busy", {31'd0, busy0}, 32'd1);
        chk("flush_run", {31'd0, run0}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_rdy", {31'd0, rdy0}, 32'd0);
        chk("rst_addr0", {24'd0, addr0}, 32'h00);
        chk("rst_addr1", {24'd0, addr1}, 32'hFE);
        chk("rst_outs", {24'd0, data0, wren0, busy0, halt0, run0, done0, err0},
            32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {31'd0, rdy0}, 32'd1);

        // basic three byte load
        in_valid = 1'b1;
        in_data  = 8'h03;
        @(negedge clk);
        chk("len_busy", {29'd0, busy0, halt0, rdy0}, 32'b110);
        in_valid = 1'b0;
        @(negedge clk);
        chk("data_nowren", {31'd0, wren0}, 32'd0);
        put(8'hAA);
        chk("w0", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'h00, 8'hAA});
        put(8'hBB);
        chk("w1", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'h01, 8'hBB});
        put(8'hCC);
        chk("w2", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'h02, 8'hCC});
        tail(8'h31);
        chk("start_run", {31'd0, run0}, 32'd1);
        chk("start_halt", {30'd0, busy0, halt0}, 32'd0);
        chk("start_done", {30'd0, done0, err0}, 32'b10);
        chk("start_wren", {31'd0, wren0}, 32'd0);
        @(negedge clk);
        chk("run_once", {31'd0, run0}, 32'd0);
        chk("back_idle_rdy", {31'd0, rdy0}, 32'd1);

        // address wrap on the FE-based instance
        start_load(8'h03);
        put(8'h11);
        chk("wrap0", {16'd0, addr1, data1}, {16'd0, 8'hFE, 8'h11});
        put(8'h22);
        chk("wrap1", {16'd0, addr1, data1}, {16'd0, 8'hFF, 8'h22});
        put(8'h33);
        chk("wrap2", {15'd0, wren1, addr1, data1}, {15'd0, 1'b1, 8'h00, 8'h33});
        tail(8'h66);
        chk("wrap_done", {30'd0, done1, run1}, 32'b11);
        @(negedge clk);

        // stall gap inside DATA
        start_load(8'h02);
        put(8'h55);
        chk("gap_w0", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'h00, 8'h55});
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap_nowren", {31'd0, wren0}, 32'd0);
        end
        put(8'h66);
        chk("gap_w1", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'h01, 8'h66});
        tail(8'hBB);
        chk("gap_run", {31'd0, run0}, 32'd1);
        @(negedge clk);

        // abort mid-stream, byte in abort cycle discarded
        start_load(8'h04);
        chk("ab_done_clr", {31'd0, done0}, 32'd0);
        put(8'h01);
        put(8'h02);
        chk("ab_w1", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'h01, 8'h02});
        in_valid = 1'b1;
        in_data  = 8'h03;
        abort    = 1'b1;
        @(negedge clk);
        chk("ab_state", {26'd0, wren0, busy0, run0, done0, err0, halt0},
            32'b000010);
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ab_after", {29'd0, wren0, run0, err0}, 32'b001);

        // length 0 means 256 bytes
        start_load(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i) ^ 8'h5A;
            put(b);
            chk("full_w", {15'd0, wren0, addr0, data0}, {15'd0, 1'b1, 8'(i), b});
        end
        tail(8'h80);
        runs = 0;
        for (int i = 0; i < 4; i++) begin
            if (run0) runs++;
            @(negedge clk);
        end
        chk("full_runs", runs, 1);
        chk("full_done", {30'd0, done0, err0}, 32'b10);

`ifdef PROG_LOADER_CHECKSUM_EN
        start_load(8'h02);
        put(8'h10);
        put(8'h20);
        tail(8'h30);
        chk("cs_ok_run", {30'd0, run0, done0}, 32'b11);
        @(negedge clk);
        start_load(8'h02);
        put(8'h10);
        put(8'h20);
        put(8'h31);
        chk("cs_bad", {28'd0, err0, done0, busy0, wren0}, 32'b1000);
        @(negedge clk);
        chk("cs_bad_norun", {31'd0, run0}, 32'd0);
`endif

        // async reset mid-DATA
        start_load(8'h03);
        put(8'h01);
        chk("pre_rst_wren", {31'd0, wren0}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outs", {24'd0, data0, wren0, busy0, halt0, run0, done0, err0},
            32'd0);
        chk("arst_addr", {16'd0, addr0, addr1}, {16'd0, 8'h00, 8'hFE});
        chk("arst_rdy", {31'd0, rdy0}, 32'd0);
        @(negedge clk);
        chk("arst_hold", {30'd0, wren0, busy0}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("arst_idle", {29'd0, rdy0, wren0, busy0}, 32'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
